// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard unit.
//   md_state_t : multi-cycle mult/div stall FSM states
//   FWD_*      : forward-mux select encodings driven on forwardAE/forwardBE
package hazard_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_WAIT = 1'b1
  } md_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter.
//   clk, rst : clock, synchronous active-high reset (clears count)
//   inc      : event this cycle; count advances on the following edge
//   cnt      : current count, holds at all-ones instead of wrapping
module hazard_perf_cnt #(
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [PERF_W-1:0] cnt
);

  localparam logic [PERF_W-1:0] ONE = PERF_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage pipeline: forwarding selects, load-use / RAW
// stalls, mispredict flushes, multi-cycle mult/div stall FSM with abort, and
// saturating stall/flush performance counters.
//   inputs : source regs in D/E, dest regs + write enables in E/M/W,
//            memtoregE, pred_takeD, pred_resM, mdstartE, mddoneE
//   outputs: forwardAE/BE, stallF/D/E, flushD/E/M (combinational),
//            md_abort, md_busy (registered), perf_stall_cnt, perf_flush_cnt
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W  = 5,
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  rsD,
  input  logic [REG_W-1:0]  rtD,
  input  logic [REG_W-1:0]  rsE,
  input  logic [REG_W-1:0]  rtE,
  input  logic [REG_W-1:0]  writeregE,
  input  logic [REG_W-1:0]  writeregM,
  input  logic [REG_W-1:0]  writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoregE,
  input  logic              pred_takeD,
  input  logic              pred_resM,
  input  logic              mdstartE,
  input  logic              mddoneE,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              md_abort,
  output logic              md_busy,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);

  md_state_t state, state_next;
  logic      dstall, mdstall, abort_next;

  // Forwarding: M has priority over W; r0 never forwards.
  always_comb begin
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    if (FWD_EN) begin
      if ((rsE != '0) && regwriteM && (rsE == writeregM))      forwardAE = FWD_M;
      else if ((rsE != '0) && regwriteW && (rsE == writeregW)) forwardAE = FWD_W;
      if ((rtE != '0) && regwriteM && (rtE == writeregM))      forwardBE = FWD_M;
      else if ((rtE != '0) && regwriteW && (rtE == writeregW)) forwardBE = FWD_W;
    end
  end

  // Without forwarding every RAW against E or M must wait; W is write-first.
  always_comb begin
    dstall = 1'b0;
    if (FWD_EN) begin
      dstall = memtoregE && regwriteE && (writeregE != '0) &&
               ((writeregE == rsD) || (writeregE == rtD));
    end else begin
      dstall = ((rsD != '0) && ((regwriteE && (rsD == writeregE)) ||
                                (regwriteM && (rsD == writeregM)))) ||
               ((rtD != '0) && ((regwriteE && (rtD == writeregE)) ||
                                (regwriteM && (rtD == writeregM))));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MD_IDLE;
      md_abort <= 1'b0;
    end else begin
      state    <= state_next;
      md_abort <= abort_next;
    end
  end

  // A mispredict kills the E op whether it is waiting or just starting.
  always_comb begin
    state_next = state;
    abort_next = 1'b0;
    mdstall    = 1'b0;
    case (state)
      MD_IDLE: begin
        mdstall    = mdstartE && !mddoneE && !pred_resM;
        abort_next = mdstartE && pred_resM;
        if (mdstartE && !pred_resM && !mddoneE) state_next = MD_WAIT;
      end
      MD_WAIT: begin
        mdstall    = !mddoneE;
        abort_next = pred_resM;
        if (pred_resM || mddoneE) state_next = MD_IDLE;
      end
      default: state_next = MD_IDLE;
    endcase
  end

  assign md_busy = (state == MD_WAIT);

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    if (pred_resM) begin
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
    end else if (mdstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      flushM = 1'b1;
    end else if (dstall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end else if (pred_takeD) begin
      flushD = 1'b1;
    end
  end

  hazard_perf_cnt #(.PERF_W(PERF_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stallF),
    .cnt (perf_stall_cnt)
  );

  hazard_perf_cnt #(.PERF_W(PERF_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pred_resM),
    .cnt (perf_flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: the driver applies directed vectors and queues the
// expected responses; a monitor on the falling edge pops and compares.
//   u_a : FWD_EN=1, PERF_W=32    u_b : FWD_EN=0, PERF_W=4
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE;
  logic       pred_takeD, pred_resM, mdstartE, mddoneE;

  logic [1:0]  fa_a, fb_a, fa_b, fb_b;
  logic        sF_a, sD_a, sE_a, fD_a, fE_a, fM_a, ab_a, bz_a;
  logic        sF_b, sD_b, sE_b, fD_b, fE_b, fM_b, ab_b, bz_b;
  logic [31:0] stc_a, flc_a;
  logic [3:0]  stc_b, flc_b;
  logic [11:0] ctl_a, ctl_b;

  assign ctl_a = {fa_a, fb_a, sF_a, sD_a, sE_a, fD_a, fE_a, fM_a, ab_a, bz_a};
  assign ctl_b = {fa_b, fb_b, sF_b, sD_b, sE_b, fD_b, fE_b, fM_b, ab_b, bz_b};

  // {fwdA, fwdB, stallF, stallD, stallE, flushD, flushE, flushM, abort, busy}
  localparam logic [11:0] K_IDLE   = 12'b00_00_000_000_0_0;
  localparam logic [11:0] K_DSTALL = 12'b00_00_110_010_0_0;
  localparam logic [11:0] K_MD     = 12'b00_00_111_001_0_0;
  localparam logic [11:0] K_MDW    = 12'b00_00_111_001_0_1;
  localparam logic [11:0] K_BUSY   = 12'b00_00_000_000_0_1;
  localparam logic [11:0] K_FLUSH  = 12'b00_00_000_111_0_0;
  localparam logic [11:0] K_FLUSHB = 12'b00_00_000_111_0_1;
  localparam logic [11:0] K_ABORT  = 12'b00_00_000_000_1_0;
  localparam logic [11:0] K_PTK    = 12'b00_00_000_100_0_0;
  localparam logic [11:0] K_FMM    = 12'b10_10_000_000_0_0;
  localparam logic [11:0] K_FWW    = 12'b01_01_000_000_0_0;
  localparam logic [11:0] K_F0W    = 12'b00_01_000_000_0_0;
  localparam logic [11:0] K_FM0    = 12'b10_00_000_000_0_0;

  hazard_ctrl #(.REG_W(5), .FWD_EN(1'b1), .PERF_W(32)) u_a (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .pred_takeD(pred_takeD), .pred_resM(pred_resM),
    .mdstartE(mdstartE), .mddoneE(mddoneE),
    .forwardAE(fa_a), .forwardBE(fb_a), .stallF(sF_a), .stallD(sD_a), .stallE(sE_a),
    .flushD(fD_a), .flushE(fE_a), .flushM(fM_a), .md_abort(ab_a), .md_busy(bz_a),
    .perf_stall_cnt(stc_a), .perf_flush_cnt(flc_a)
  );

  hazard_ctrl #(.REG_W(5), .FWD_EN(1'b0), .PERF_W(4)) u_b (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .pred_takeD(pred_takeD), .pred_resM(pred_resM),
    .mdstartE(mdstartE), .mddoneE(mddoneE),
    .forwardAE(fa_b), .forwardBE(fb_b), .stallF(sF_b), .stallD(sD_b), .stallE(sE_b),
    .flushD(fD_b), .flushE(fE_b), .flushM(fM_b), .md_abort(ab_b), .md_busy(bz_b),
    .perf_stall_cnt(stc_b), .perf_flush_cnt(flc_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       nm;
    int          d;   // 0 = u_a, 1 = u_b
    int          k;   // 0 = control vector, 1 = stall count, 2 = flush count
    logic [31:0] v;
  } item_t;

  item_t q[$];
  item_t it;
  int    checks = 0;
  int    errors = 0;

  task automatic ectl(input string nm, input int d, input logic [11:0] v);
    item_t e;
    e.cyc = cyc; e.nm = nm; e.d = d; e.k = 0; e.v = {20'b0, v};
    q.push_back(e);
  endtask

  task automatic ecnt(input string nm, input int d, input int k, input int unsigned v);
    item_t e;
    e.cyc = cyc; e.nm = nm; e.d = d; e.k = k; e.v = v;
    q.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int d, input int k);
    if (k == 0) return (d == 0) ? {20'b0, ctl_a} : {20'b0, ctl_b};
    if (k == 1) return (d == 0) ? stc_a : {28'b0, stc_b};
    return (d == 0) ? flc_a : {28'b0, flc_b};
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      it = q.pop_front();
      checks++;
      if (actual(it.d, it.k) !== it.v) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", it.nm, actual(it.d, it.k), it.v);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0; memtoregE = 1'b0;
    pred_takeD = 1'b0; pred_resM = 1'b0; mdstartE = 1'b0; mddoneE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    ectl("rst_ctl_a", 0, K_IDLE); ecnt("rst_stc_a", 0, 1, 0);
    ecnt("rst_flc_a", 0, 2, 0);   ectl("rst_ctl_b", 1, K_IDLE);

    // forwarding
    tick(); rsE = 5; rtE = 5; writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1;
    ectl("fwd_mm_a", 0, K_FMM); ectl("fwd_off_b", 1, K_IDLE);
    tick(); regwriteM = 0;
    ectl("fwd_ww_a", 0, K_FWW);
    tick(); rsE = 0;
    ectl("fwd_rs0_a", 0, K_F0W);
    tick(); rtE = 0; writeregM = 0; regwriteM = 1; writeregW = 0;
    ectl("fwd_r0_a", 0, K_IDLE);

    // load-use with predicted-taken branch in D
    tick(); clr(); memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8; pred_takeD = 1;
    ectl("lu_a", 0, K_DSTALL); ectl("lu_b", 1, K_DSTALL);
    tick(); memtoregE = 0; pred_takeD = 0;
    ectl("lu_rel_a", 0, K_IDLE); ecnt("lu_stc_a", 0, 1, 1);
    ectl("lu_rel_b", 1, K_DSTALL); ecnt("lu_stc_b", 1, 1, 1);
    tick(); clr(); pred_takeD = 1;
    ectl("ptk_a", 0, K_PTK); ectl("ptk_b", 1, K_PTK);

    tick(); clr(); rst = 1;
    tick(); rst = 0;
    ecnt("clr_stc_a", 0, 1, 0); ecnt("clr_stc_b", 1, 1, 0);

    // divider: start + 5 wait cycles stalled, done cycle not stalled
    tick(); mdstartE = 1;
    ectl("md_start", 0, K_MD);
    for (int i = 1; i < 6; i++) begin
      tick(); ectl("md_wait", 0, K_MDW);
    end
    tick(); mddoneE = 1;
    ectl("md_done", 0, K_BUSY); ecnt("md_done_stc", 0, 1, 6);
    tick(); clr();
    ectl("md_end", 0, K_IDLE); ecnt("md_stc", 0, 1, 6);
    tick(); mdstartE = 1; mddoneE = 1;
    ectl("md_inst", 0, K_IDLE);
    tick(); clr();
    ectl("md_inst_idle", 0, K_IDLE);

    // abort on 3rd wait cycle
    tick(); mdstartE = 1;
    ectl("ab_start", 0, K_MD);
    tick(); ectl("ab_w1", 0, K_MDW);
    tick(); ectl("ab_w2", 0, K_MDW);
    tick(); pred_resM = 1;
    ectl("ab_res", 0, K_FLUSHB);
    tick(); clr();
    ectl("ab_pulse", 0, K_ABORT); ecnt("ab_flc", 0, 2, 1);
    tick();
    ectl("ab_done", 0, K_IDLE); ecnt("ab_stc", 0, 1, 9);

    // mispredict overrides an idle start, a load-use and a predicted branch
    tick(); mdstartE = 1; pred_resM = 1; pred_takeD = 1;
    memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8;
    ectl("iab_a", 0, K_FLUSH);
    tick(); clr();
    ectl("iab_pulse", 0, K_ABORT); ecnt("iab_flc", 0, 2, 2);

    // no forwarding
    tick(); writeregM = 3; regwriteM = 1; rtD = 3; rsE = 3;
    ectl("nf_b", 1, K_DSTALL); ectl("nf_a", 0, K_FM0);
    tick(); clr(); writeregW = 3; regwriteW = 1; rsD = 3;
    ectl("nf_w_b", 1, K_IDLE);

    // mdstall absorbs a load-use and a predicted branch
    tick(); clr(); mdstartE = 1; memtoregE = 1; regwriteE = 1; writeregE = 8;
    rsD = 8; pred_takeD = 1;
    ectl("abs_a", 0, K_MD);
    tick(); clr(); mddoneE = 1;
    ectl("abs_done", 0, K_BUSY);
    tick(); clr();
    ectl("abs_idle", 0, K_IDLE);

    // reset in the middle of MD_WAIT
    tick(); mdstartE = 1;
    tick(); ectl("rw_busy", 0, K_MDW);
    tick(); rst = 1;
    tick(); rst = 0; clr();
    ectl("rw_ctl_a", 0, K_IDLE); ecnt("rw_stc_a", 0, 1, 0); ecnt("rw_flc_a", 0, 2, 0);
    ectl("rw_ctl_b", 1, K_IDLE); ecnt("rw_stc_b", 1, 1, 0);

    // saturation of the 4-bit stall counter on u_b
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) begin
        writeregE = 8; regwriteE = 1; rsD = 8;
        ectl("sat_ctl_b", 1, K_DSTALL); ectl("sat_ctl_a", 0, K_IDLE);
      end
      if (i == 14) ecnt("sat14_b", 1, 1, 14);
      if (i == 15) ecnt("sat15_b", 1, 1, 15);
    end
    tick(); clr();
    ecnt("sat_end_b", 1, 1, 15); ecnt("sat_end_a", 0, 1, 0);

    tick(); tick();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
